// File: rtl/pwm_ramp_ctrl.sv
// Ramp controller for a downstream PWM generator: accepts a period/target/step/hold
// configuration and walks the compare value toward the target one step per hold window.
module pwm_ramp_ctrl #(
    parameter logic [31:0] ARR_DEFAULT = 32'd49999
) (
    input  logic        Clk50M,
    input  logic        Rst_n,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_arr,
    input  logic [31:0] cfg_target,
    input  logic [15:0] cfg_step,
    input  logic [15:0] cfg_hold,
    output logic        cnt_en,
    output logic [31:0] counter_arr,
    output logic [31:0] counter_ccr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RAMP    = 2'd2,
        SETTLED = 2'd3
    } stateT;

    stateT       r_state;
    stateT       w_nextState;

    logic [31:0] r_arr;
    logic [31:0] r_ccr;
    logic [31:0] r_target;
    logic [15:0] r_step;
    logic [15:0] r_hold;
    logic [31:0] r_pcnt;
    logic [15:0] r_holdCnt;
    logic        r_done;

    logic        w_accept;
    logic        w_running;
    logic        w_periodTick;
    logic        w_holdDone;
    logic        w_stepNow;
    logic        w_doneNext;
    logic [32:0] w_arrPlus1;
    logic [31:0] w_clampTarget;
    logic [32:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_stepCcr;

    // Rst_n is folded in so the handshake stays closed while reset is held.
    assign cfg_ready    = Rst_n & enable & ((r_state == IDLE) || (r_state == SETTLED));
    assign w_accept     = cfg_valid & cfg_ready;
    assign w_running    = (r_state == RAMP) || (r_state == SETTLED);
    assign w_periodTick = w_running & (r_pcnt == 32'd0);
    assign w_holdDone   = (r_holdCnt == r_hold);
    assign w_stepNow    = enable & (r_state == RAMP) & w_periodTick & w_holdDone;

    assign cnt_en      = w_running;
    assign busy        = (r_state == LOAD) || (r_state == RAMP);
    assign done        = r_done;
    assign counter_arr = r_arr;
    assign counter_ccr = r_ccr;

    always_comb begin
        w_arrPlus1    = {1'b0, cfg_arr} + 33'd1;
        w_clampTarget = cfg_target;
        if ({1'b0, cfg_target} > w_arrPlus1) begin
            w_clampTarget = w_arrPlus1[32] ? 32'hFFFF_FFFF : w_arrPlus1[31:0];
        end
    end

    // Saturating step toward the target; 33-bit sum guards against wrap on the way up.
    always_comb begin
        w_sum     = {1'b0, r_ccr} + {17'd0, r_step};
        w_diff    = r_ccr - r_target;
        w_stepCcr = r_ccr;
        if (r_step == 16'd0) begin
            w_stepCcr = r_target;
        end else if (r_ccr < r_target) begin
            w_stepCcr = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[31:0];
        end else if (w_diff <= {16'd0, r_step}) begin
            w_stepCcr = r_target;
        end else begin
            w_stepCcr = r_ccr - {16'd0, r_step};
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_doneNext  = 1'b0;
        if (!enable) begin
            w_nextState = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_nextState = LOAD;
                    end
                end
                LOAD: begin
                    if (r_ccr == r_target) begin
                        w_nextState = SETTLED;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_nextState = RAMP;
                    end
                end
                RAMP: begin
                    if (w_stepNow && (w_stepCcr == r_target)) begin
                        w_nextState = SETTLED;
                        w_doneNext  = 1'b1;
                    end
                end
                SETTLED: begin
                    if (w_accept) begin
                        w_nextState = LOAD;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // pcnt mirrors the generator counter as (arr - count), so pcnt==0 marks the last cycle of a period.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_arr     <= ARR_DEFAULT;
            r_ccr     <= 32'd0;
            r_target  <= 32'd0;
            r_step    <= 16'd0;
            r_hold    <= 16'd0;
            r_pcnt    <= 32'd0;
            r_holdCnt <= 16'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_doneNext;

            if (w_accept) begin
                r_arr    <= cfg_arr;
                r_target <= w_clampTarget;
                r_step   <= cfg_step;
                r_hold   <= cfg_hold;
            end

            if (enable && (r_state == LOAD)) begin
                r_pcnt <= r_arr;
            end else if (enable && w_running) begin
                r_pcnt <= (r_pcnt == 32'd0) ? r_arr : (r_pcnt - 32'd1);
            end

            if (w_accept) begin
                r_holdCnt <= 16'd0;
            end else if (enable && (r_state == RAMP) && w_periodTick) begin
                r_holdCnt <= w_holdDone ? 16'd0 : (r_holdCnt + 16'd1);
            end

            if (w_stepNow) begin
                r_ccr <= w_stepCcr;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps up, ramps down, clamped jump, enable drop,
// asynchronous reset mid-ramp and an immediate settle out of LOAD.
module tb_pwm_ramp_ctrl;

    logic        Clk50M;
    logic        Rst_n;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_arr;
    logic [31:0] cfg_target;
    logic [15:0] cfg_step;
    logic [15:0] cfg_hold;
    logic        cnt_en;
    logic [31:0] counter_arr;
    logic [31:0] counter_ccr;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] expSeq [0:7];

    pwm_ramp_ctrl #(.ARR_DEFAULT(32'd49999)) dut (
        .Clk50M      (Clk50M),
        .Rst_n       (Rst_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_arr     (cfg_arr),
        .cfg_target  (cfg_target),
        .cfg_step    (cfg_step),
        .cfg_hold    (cfg_hold),
        .cnt_en      (cnt_en),
        .counter_arr (counter_arr),
        .counter_ccr (counter_ccr),
        .busy        (busy),
        .done        (done)
    );

    initial Clk50M = 1'b0;
    always #10 Clk50M = ~Clk50M;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [31:0] arr,
                                 input logic [31:0] target, input logic [15:0] step, input logic [15:0] hold);
        enable     = en;
        cfg_valid  = valid;
        cfg_arr    = arr;
        cfg_target = target;
        cfg_step   = step;
        cfg_hold   = hold;
    endtask

    // Called just after a negedge with a config offered; walks LOAD and then the ramp
    // cycle by cycle, expecting ccr to hold expSeq[n] for each whole step window.
    task automatic runRamp(input int period, input int holdP1, input int nSteps, input int stopK);
        int total;
        int window;
        total  = period * holdP1 * nSteps;
        window = period * holdP1;
        @(negedge Clk50M);
        checkFlag("load cnt_en", cnt_en, 1'b0);
        checkFlag("load busy", busy, 1'b1);
        checkFlag("load cfg_ready", cfg_ready, 1'b0);
        checkFlag("load done", done, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd1, 16'd5, 16'd3);
        for (int k = 0; k <= stopK; k++) begin
            @(negedge Clk50M);
            checkOutput($sformatf("ramp ccr k=%0d", k), counter_ccr, expSeq[k / window]);
            checkFlag($sformatf("ramp cnt_en k=%0d", k), cnt_en, 1'b1);
            checkFlag($sformatf("ramp done k=%0d", k), done, k == total);
            checkFlag($sformatf("ramp busy k=%0d", k), busy, k < total);
        end
        if (stopK == total) begin
            @(negedge Clk50M);
            checkFlag("settled done clear", done, 1'b0);
            checkFlag("settled busy", busy, 1'b0);
            checkFlag("settled cnt_en", cnt_en, 1'b1);
            checkFlag("settled cfg_ready", cfg_ready, 1'b1);
            checkOutput("settled ccr", counter_ccr, expSeq[nSteps]);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 16'd0);

        // Reset values, with enable already high
        #25;
        checkFlag("reset cfg_ready", cfg_ready, 1'b0);
        checkFlag("reset cnt_en", cnt_en, 1'b0);
        checkOutput("reset arr", counter_arr, 32'd49999);
        checkOutput("reset ccr", counter_ccr, 32'd0);
        checkFlag("reset busy", busy, 1'b0);
        checkFlag("reset done", done, 1'b0);
        @(negedge Clk50M);
        Rst_n = 1'b1;
        #1;
        checkFlag("release cfg_ready", cfg_ready, 1'b1);
        checkFlag("release cnt_en", cnt_en, 1'b0);

        // Ramp up 0 -> 10 by 2 every period of 10 cycles
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd10, 16'd2, 16'd0);
        expSeq[0] = 32'd0; expSeq[1] = 32'd2; expSeq[2] = 32'd4;
        expSeq[3] = 32'd6; expSeq[4] = 32'd8; expSeq[5] = 32'd10;
        runRamp(10, 1, 5, 50);
        checkOutput("up arr", counter_arr, 32'd9);

        // Ramp down 10 -> 3 by 4 every two periods, final step saturates at target
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd3, 16'd4, 16'd1);
        expSeq[0] = 32'd10; expSeq[1] = 32'd6; expSeq[2] = 32'd3;
        runRamp(10, 2, 2, 40);

        // Jump with target above arr+1 clamps to 100 (full duty)
        applyStimulus(1'b1, 1'b1, 32'd99, 32'd500, 16'd0, 16'd0);
        expSeq[0] = 32'd3; expSeq[1] = 32'd100;
        runRamp(100, 1, 1, 100);
        checkOutput("clamp arr", counter_arr, 32'd99);

        // Jump back to 0 to set up the enable-drop case
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd0, 16'd0, 16'd0);
        expSeq[0] = 32'd100; expSeq[1] = 32'd0;
        runRamp(10, 1, 1, 10);

        // Drop enable at ccr=4 while offering a new config
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd10, 16'd2, 16'd0);
        expSeq[0] = 32'd0; expSeq[1] = 32'd2; expSeq[2] = 32'd4;
        expSeq[3] = 32'd6; expSeq[4] = 32'd8; expSeq[5] = 32'd10;
        runRamp(10, 1, 5, 20);
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd7, 16'd1, 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk50M);
            checkFlag($sformatf("disable cnt_en %0d", i), cnt_en, 1'b0);
            checkFlag($sformatf("disable busy %0d", i), busy, 1'b0);
            checkFlag($sformatf("disable done %0d", i), done, 1'b0);
            checkFlag($sformatf("disable cfg_ready %0d", i), cfg_ready, 1'b0);
            checkOutput($sformatf("disable ccr %0d", i), counter_ccr, 32'd4);
            checkOutput($sformatf("disable arr %0d", i), counter_arr, 32'd9);
        end

        // Restart from ccr=4, then assert reset off the clock edge mid-ramp
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd10, 16'd2, 16'd0);
        expSeq[0] = 32'd4; expSeq[1] = 32'd6; expSeq[2] = 32'd8; expSeq[3] = 32'd10;
        runRamp(10, 1, 3, 15);
        #5;
        Rst_n = 1'b0;
        #1;
        checkOutput("async reset ccr", counter_ccr, 32'd0);
        checkOutput("async reset arr", counter_arr, 32'd49999);
        checkFlag("async reset cnt_en", cnt_en, 1'b0);
        checkFlag("async reset busy", busy, 1'b0);
        checkFlag("async reset done", done, 1'b0);
        checkFlag("async reset cfg_ready", cfg_ready, 1'b0);
        repeat (3) begin
            @(negedge Clk50M);
            checkFlag("in reset done", done, 1'b0);
        end
        Rst_n = 1'b1;
        #1;
        checkFlag("re-release cfg_ready", cfg_ready, 1'b1);
        checkFlag("re-release cnt_en", cnt_en, 1'b0);
        @(negedge Clk50M);
        checkFlag("post reset done", done, 1'b0);
        checkFlag("post reset busy", busy, 1'b0);

        // Target equal to current ccr settles straight out of LOAD
        applyStimulus(1'b1, 1'b1, 32'd9, 32'd0, 16'd3, 16'd0);
        @(negedge Clk50M);
        checkFlag("direct load cnt_en", cnt_en, 1'b0);
        checkFlag("direct load busy", busy, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'd0, 16'd3, 16'd0);
        @(negedge Clk50M);
        checkFlag("direct settle cnt_en", cnt_en, 1'b1);
        checkFlag("direct settle busy", busy, 1'b0);
        checkFlag("direct settle done", done, 1'b1);
        checkOutput("direct settle ccr", counter_ccr, 32'd0);
        checkOutput("direct settle arr", counter_arr, 32'd9);
        @(negedge Clk50M);
        checkFlag("direct done clear", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter ARR_DEFAULT, default 32'd49999, counter_arr value driven out of reset (1 kHz at 50 MHz).
REQ-002 SHALL have port Clk50M  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port enable  input  1  block enable; low forces IDLE.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  configuration accept-ready.
REQ-007 SHALL have port cfg_arr  input  32  period reload value (period = arr+1 cycles).
REQ-008 SHALL have port cfg_target  input  32  target compare value.
REQ-009 SHALL have port cfg_step  input  16  compare increment per step; 0 = jump.
REQ-010 SHALL have port cfg_hold  input  16  periods between steps minus one.
REQ-011 SHALL have port cnt_en  output  1  count enable to downstream PWM generator.
REQ-012 SHALL have port counter_arr  output  32  period reload to generator.
REQ-013 SHALL have port counter_ccr  output  32  compare value to generator (output high while generator counter < ccr).
REQ-014 SHALL have ports busy  output  1  (ramp in progress) and done  output  1  (one-cycle pulse on target reached).

Function
REQ-015 SHALL implement states IDLE, LOAD, RAMP, SETTLED.
REQ-016 cfg_ready SHALL equal enable AND (state IDLE or SETTLED); accept = cfg_valid AND cfg_ready.
REQ-017 On accept: latch cfg_arr into counter_arr, latch clamped target, step, hold; next state LOAD.
REQ-018 Target clamp: if cfg_target > cfg_arr+1 (33-bit compare), target = cfg_arr+1; if cfg_arr = 32'hFFFFFFFF, clamp to 32'hFFFFFFFF.
REQ-019 LOAD SHALL last exactly one cycle with cnt_en=0, loading internal period counter pcnt with counter_arr; then RAMP, or SETTLED if counter_ccr already equals target.
REQ-020 In RAMP and SETTLED cnt_en SHALL be 1; pcnt decrements each cycle, reloads counter_arr at 0, tracking the generator counter exactly.
REQ-021 period_tick SHALL be asserted when cnt_en=1 and pcnt=0; counter_ccr SHALL change only on period_tick (glitch-free, effective at next period start).
REQ-022 Hold counter SHALL count period_ticks; a step occurs on the (cfg_hold+1)-th tick, then hold counter restarts.
REQ-023 Step up: ccr = min(ccr+step, target) in 33-bit arithmetic; step down: ccr = max(ccr-step, target), no underflow; step 0: ccr = target on first step tick.
REQ-024 When counter_ccr equals target after a step (or at LOAD exit), state SHALL go SETTLED and done SHALL pulse for exactly one cycle.
REQ-025 busy SHALL be 1 in LOAD and RAMP, else 0.
REQ-026 enable low in any state SHALL within one cycle give state IDLE, cnt_en=0, no accept; counter_ccr and counter_arr retain values.
REQ-027 enable low with cfg_valid high same cycle: enable wins, config not accepted.
REQ-028 Accept in SETTLED SHALL restart via LOAD from current counter_ccr toward new target; pending hold count discarded.
REQ-029 cfg inputs ignored outside the accept cycle.

Reset
REQ-030 Rst_n low SHALL asynchronously set state IDLE, cnt_en=0, counter_arr=ARR_DEFAULT, counter_ccr=0, busy=0, done=0, pcnt=0, hold counter=0.
REQ-031 cfg_ready SHALL be 0 during reset and equal enable on first cycle after release.
REQ-032 Reset mid-ramp SHALL abandon the ramp with no done pulse.

Verification
REQ-033 Reset release, enable=1, cfg arr=9 target=10 step=2 hold=0 -> ccr 0,2,4,6,8,10 each changing at period_tick (every 10 cycles); done pulses once on ccr=10; SETTLED with cnt_en=1.
REQ-034 From ccr=10, arr=9, target=3 step=4 hold=1 -> ccr 6 after 2 periods, 3 after 4 periods (no underflow); done pulse.
REQ-035 arr=99 target=500 step=0 -> target clamps to 100; ccr=100 at first period_tick; 100% duty at generator.
REQ-036 enable dropped during RAMP at ccr=4 -> next cycle IDLE, cnt_en=0, ccr stays 4; cfg_valid in same cycle not accepted.
REQ-037 Rst_n asserted mid-ramp asynchronously (off clock edge) -> outputs immediately reset values; no done pulse.
REQ-038 Throughout: check cnt_en=0 exactly one cycle in LOAD and counter_ccr never changes except on cycles with pcnt=0.
